spatial_sram_scheduler: RTL and testbench

- Shares one single-port item-memory/projection SRAM among the three modality channel walkers of the spatial encoder.
- Each SRAM word holds {iM, projM_neg, projM_pos} for one channel.
- Round-robin arbitration of per-modality read requests; per-modality base offset added to the local channel address.
- SRAM latency is tracked with an ID-tag pipeline; read data is returned on one shared, flow-controlled response channel, so encoder stalls never lose data.

---
 rtl/spatial_sram_scheduler_pkg.sv | 31 +++
 rtl/spatial_sram_scheduler_sched_rsp_fifo.sv | 88 ++++++++
 rtl/spatial_sram_scheduler.sv | 157 +++++++++++++++
 tb/tb_spatial_sram_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatial_sram_scheduler_pkg.sv
// Shared types and constants for the spatial encoder SRAM scheduler.
package spatial_sram_scheduler_pkg;

  localparam int SCHED_NUM_REQ = 3;
  localparam int ID_W          = 2;
  localparam int PERF_W        = 16;

  localparam logic [ID_W-1:0] MOD1_ID = 2'd0;
  localparam logic [ID_W-1:0] MOD2_ID = 2'd1;
  localparam logic [ID_W-1:0] MOD3_ID = 2'd2;

  localparam int FIRST_MODALITY_CHANNELS  = 32;
  localparam int SECOND_MODALITY_CHANNELS = 77;

  // Channel tables of the three modalities are packed back to back in the SRAM.
  localparam int MOD2_BASE_DEF = FIRST_MODALITY_CHANNELS;
  localparam int MOD3_BASE_DEF = FIRST_MODALITY_CHANNELS + SECOND_MODALITY_CHANNELS;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [ID_W-1:0] rr_add(input logic [ID_W-1:0] k, input logic [ID_W-1:0] n);
    logic [ID_W:0] s;
    s = {1'b0, k} + {1'b0, n};
    if (s >= 3'(SCHED_NUM_REQ)) s = s - 3'(SCHED_NUM_REQ);
    return s[ID_W-1:0];
  endfunction

endpackage

// File: rtl/spatial_sram_scheduler_sched_rsp_fifo.sv
// Response FIFO with a registered head entry; capacity DEPTH including the output register.
// Sync active-high reset, full/empty/count status.
module sched_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_dat_i,
  input  logic                       rd_en_i,
  output logic                       rd_vld_o,
  output logic [WIDTH-1:0]           rd_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic             pop, load_out, mem_empty, bypass, mem_wr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign pop       = out_vld_q & rd_en_i;
  assign mem_empty = (count_q == CNT_W'(out_vld_q));
  assign load_out  = ~out_vld_q | pop;
  // An empty FIFO forwards the write straight into the head register.
  assign bypass    = load_out & mem_empty & wr_en_i;
  assign mem_wr    = wr_en_i & ~bypass;

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = mem_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d   = count_q + CNT_W'(wr_en_i) - CNT_W'(pop);
    if (load_out) begin
      if (!mem_empty) begin
        out_vld_d = 1'b1;
        out_dat_d = mem_q[rd_ptr_q];
        rd_ptr_d  = ptr_inc(rd_ptr_q);
      end else if (wr_en_i) begin
        out_vld_d = 1'b1;
        out_dat_d = wr_dat_i;
      end else begin
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign rd_vld_o = out_vld_q;
  assign rd_dat_o = out_dat_q;
  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;

  assert property (@(posedge clk_i) disable iff (rst_i) !(wr_en_i && full_o && !pop));

endmodule

// File: rtl/spatial_sram_scheduler.sv
// Round-robin sharing of the item-memory/projection SRAM among three modality walkers.
// Optional grant/stall counters are built when SRAM_SCHED_PERF_EN is defined.
module spatial_sram_scheduler
  import spatial_sram_scheduler_pkg::*;
#(
  parameter int DATA_W     = 6144,
  parameter int ADDR_W     = 8,
  parameter int SRAM_LAT   = 1,
  parameter int FIFO_DEPTH = 3,
  parameter int MOD2_BASE  = MOD2_BASE_DEF,
  parameter int MOD3_BASE  = MOD3_BASE_DEF
) (
  input  logic                       Clk_CI,
  input  logic                       Reset_RI,
  input  logic [SCHED_NUM_REQ-1:0]   ReqValid_SI,
  output logic [SCHED_NUM_REQ-1:0]   ReqReady_SO,
  input  logic [3*ADDR_W-1:0]        ReqAddr_DI,
  output logic                       Sram_CE_SO,
  output logic [ADDR_W-1:0]          Sram_Addr_DO,
  input  logic [DATA_W-1:0]          Sram_RData_DI,
  output logic                       RspValid_SO,
  input  logic                       RspReady_SI,
  output logic [ID_W-1:0]            RspId_DO,
  output logic [DATA_W-1:0]          RspData_DO,
  output logic                       Busy_SO
`ifdef SRAM_SCHED_PERF_EN
  ,
  input  logic                       PerfClear_SI,
  output logic [3*PERF_W-1:0]        PerfGrant_DO,
  output logic [PERF_W-1:0]          PerfStall_DO
`endif
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_W = DATA_W + ID_W;

  logic [ID_W-1:0]          rr_q, rr_d;
  logic [CRED_W-1:0]        credit_q, credit_d;
  logic [SCHED_NUM_REQ-1:0] grant;
  logic [ID_W-1:0]          win_id;
  logic                     can_issue, grant_any, rsp_pop;
  logic [ADDR_W-1:0]        sram_addr;
  tag_t                     tag_q [SRAM_LAT];

  logic                     fifo_rd_vld, fifo_full, fifo_empty;
  logic [CRED_W-1:0]        fifo_count;
  logic [FIFO_W-1:0]        fifo_rd_dat;
  logic                     fifo_status_unused;

  // Credits count every word issued but not yet popped, so the FIFO can never overflow.
  assign can_issue = (credit_q < CRED_W'(FIFO_DEPTH));

  always_comb begin
    grant  = '0;
    win_id = MOD1_ID;
    if (!Reset_RI && can_issue) begin
      for (int i = SCHED_NUM_REQ - 1; i >= 0; i--) begin
        if (ReqValid_SI[rr_add(rr_q, 2'(i))]) win_id = rr_add(rr_q, 2'(i));
      end
      grant[win_id] = |ReqValid_SI;
    end
  end

  assign grant_any = |grant;

  always_comb begin
    case (win_id)
      MOD2_ID: sram_addr = ReqAddr_DI[ADDR_W +: ADDR_W] + ADDR_W'(MOD2_BASE);
      MOD3_ID: sram_addr = ReqAddr_DI[2*ADDR_W +: ADDR_W] + ADDR_W'(MOD3_BASE);
      default: sram_addr = ReqAddr_DI[0 +: ADDR_W];
    endcase
    if (!grant_any) sram_addr = '0;
  end

  assign ReqReady_SO  = grant;
  assign Sram_CE_SO   = grant_any;
  assign Sram_Addr_DO = sram_addr;

  assign rr_d = grant_any ? rr_add(win_id, 2'd1) : rr_q;

  always_comb begin
    case ({grant_any, rsp_pop})
      2'b10:   credit_d = credit_q + CRED_W'(1);
      2'b01:   credit_d = credit_q - CRED_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      rr_q     <= MOD1_ID;
      credit_q <= '0;
    end else begin
      rr_q     <= rr_d;
      credit_q <= credit_d;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      for (int i = 0; i < SRAM_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0].vld <= grant_any;
      tag_q[0].id  <= win_id;
      for (int i = 1; i < SRAM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  sched_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_rsp_fifo (
    .clk_i    (Clk_CI),
    .rst_i    (Reset_RI),
    .wr_en_i  (tag_q[SRAM_LAT-1].vld),
    .wr_dat_i ({tag_q[SRAM_LAT-1].id, Sram_RData_DI}),
    .rd_en_i  (RspReady_SI),
    .rd_vld_o (fifo_rd_vld),
    .rd_dat_o (fifo_rd_dat),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign fifo_status_unused = fifo_full ^ fifo_empty ^ (^fifo_count);

  assign rsp_pop     = fifo_rd_vld & RspReady_SI;
  assign RspValid_SO = fifo_rd_vld;
  assign RspId_DO    = fifo_rd_dat[DATA_W +: ID_W];
  assign RspData_DO  = fifo_rd_dat[DATA_W-1:0];
  assign Busy_SO     = (credit_q != '0);

  assert property (@(posedge Clk_CI) disable iff (Reset_RI) $onehot0(grant));
  assert property (@(posedge Clk_CI) disable iff (Reset_RI) fifo_count <= credit_q);
  assert property (@(posedge Clk_CI) disable iff (Reset_RI) RspValid_SO |-> (RspId_DO != 2'd3));

`ifdef SRAM_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_grant_q [SCHED_NUM_REQ];
  logic [PERF_W-1:0] perf_stall_q;

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI || PerfClear_SI) begin
      for (int k = 0; k < SCHED_NUM_REQ; k++) perf_grant_q[k] <= '0;
      perf_stall_q <= '0;
    end else begin
      for (int k = 0; k < SCHED_NUM_REQ; k++) begin
        if (grant[k] && (perf_grant_q[k] != '1)) perf_grant_q[k] <= perf_grant_q[k] + PERF_W'(1);
      end
      if ((|ReqValid_SI) && !grant_any && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + PERF_W'(1);
    end
  end

  assign PerfGrant_DO = {perf_grant_q[2], perf_grant_q[1], perf_grant_q[0]};
  assign PerfStall_DO = perf_stall_q;
`endif

endmodule

// File: tb/tb_spatial_sram_scheduler.sv
// Self-checking bench: vector table for arbitration/address, scoreboard for responses.
module tb_spatial_sram_scheduler;

  localparam int DATA_W     = 6144;
  localparam int ADDR_W     = 8;
  localparam int SRAM_LAT   = 1;
  localparam int FIFO_DEPTH = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          req_vld, req_rdy;
  logic [3*ADDR_W-1:0] req_addr;
  logic                ce;
  logic [ADDR_W-1:0]   sram_addr;
  logic [DATA_W-1:0]   rdata = '0;
  logic                rsp_vld, rsp_rdy, busy;
  logic [1:0]          rsp_id;
  logic [DATA_W-1:0]   rsp_dat;
`ifdef SRAM_SCHED_PERF_EN
  logic                perf_clr;
  logic [47:0]         perf_grant;
  logic [15:0]         perf_stall;
`endif

  int checks   = 0;
  int failures = 0;
  int mon_pops = 0;

  typedef struct { logic [1:0] id; logic [ADDR_W-1:0] addr; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   mon_idx;

  typedef struct {
    logic [2:0]  vld;
    logic [23:0] addr;
    logic [2:0]  exp_rdy;
    logic [7:0]  exp_addr;
  } vec_t;
  vec_t tv[11];

  spatial_sram_scheduler #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRAM_LAT(SRAM_LAT), .FIFO_DEPTH(FIFO_DEPTH),
    .MOD2_BASE(32), .MOD3_BASE(109)
  ) dut (
    .Clk_CI(clk), .Reset_RI(rst), .ReqValid_SI(req_vld), .ReqReady_SO(req_rdy),
    .ReqAddr_DI(req_addr), .Sram_CE_SO(ce), .Sram_Addr_DO(sram_addr), .Sram_RData_DI(rdata),
    .RspValid_SO(rsp_vld), .RspReady_SI(rsp_rdy), .RspId_DO(rsp_id), .RspData_DO(rsp_dat),
    .Busy_SO(busy)
`ifdef SRAM_SCHED_PERF_EN
    , .PerfClear_SI(perf_clr), .PerfGrant_DO(perf_grant), .PerfStall_DO(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = {8'hC3 ^ 8'(i), a, ~a, 8'(i)};
    return w;
  endfunction

  function automatic logic [ADDR_W-1:0] base_of(input int k);
    return (k == 0) ? 8'd0 : (k == 1) ? 8'd32 : 8'd109;
  endfunction

  // SRAM model with one cycle of read latency.
  always @(posedge clk) if (ce) rdata <= word_of(sram_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [DATA_W-1:0] exp);
    checks++;
    if (rsp_dat !== exp) begin
      failures++;
      $display("FAIL %s: got low word 0x%08h expected 0x%08h", nm, rsp_dat[31:0], exp[31:0]);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", nm, n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_vld = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Scoreboard: expectation recorded at issue, compared when the response is accepted.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (rsp_vld && rsp_rdy) begin
        mon_pops++;
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got id %0d, expected no response", rsp_id);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          chk_data("rsp_data", word_of(mon_e.addr));
        end
      end
      if (ce) begin
        case (req_rdy)
          3'b001:  mon_idx = 0;
          3'b010:  mon_idx = 1;
          3'b100:  mon_idx = 2;
          default: mon_idx = -1;
        endcase
        checks++;
        if (mon_idx < 0) begin
          failures++;
          $display("FAIL grant_onehot: got 0x%0h expected one-hot with CE", req_rdy);
        end else begin
          mon_e.id   = 2'(mon_idx);
          mon_e.addr = req_addr[mon_idx*ADDR_W +: ADDR_W] + base_of(mon_idx);
          chk("issue_addr", 32'(sram_addr), 32'(mon_e.addr));
          sbq.push_back(mon_e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt, pops0, nv, nb;

    tv[0]  = '{3'b001, {8'd0,   8'd0,   8'd5},  3'b001, 8'd5};
    tv[1]  = '{3'b010, {8'd0,   8'd3,   8'd0},  3'b010, 8'd35};
    tv[2]  = '{3'b100, {8'd200, 8'd0,   8'd0},  3'b100, 8'd53};
    tv[3]  = '{3'b111, {8'd3,   8'd2,   8'd1},  3'b001, 8'd1};
    tv[4]  = '{3'b111, {8'd3,   8'd2,   8'd1},  3'b010, 8'd34};
    tv[5]  = '{3'b101, {8'd10,  8'd0,   8'd7},  3'b100, 8'd119};
    tv[6]  = '{3'b110, {8'd255, 8'd0,   8'd0},  3'b010, 8'd32};
    tv[7]  = '{3'b011, {8'd0,   8'd250, 8'd9},  3'b001, 8'd9};
    tv[8]  = '{3'b000, {8'd0,   8'd0,   8'd0},  3'b000, 8'd0};
    tv[9]  = '{3'b101, {8'd0,   8'd0,   8'd4},  3'b100, 8'd109};
    tv[10] = '{3'b010, {8'd0,   8'd255, 8'd0},  3'b010, 8'd31};

    rst = 1'b1;
    req_vld = 3'b111;
    req_addr = '0;
    rsp_rdy = 1'b1;
`ifdef SRAM_SCHED_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_rdy), 32'd0);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk_data("rst_rsp_data", '0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_vld = '0;

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      req_vld = tv[i].vld;
      req_addr = tv[i].addr;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(req_rdy), 32'(tv[i].exp_rdy));
      chk($sformatf("vec%0d_ce", i), 32'(ce), 32'(|tv[i].exp_rdy));
      if (|tv[i].exp_rdy) chk($sformatf("vec%0d_addr", i), 32'(sram_addr), 32'(tv[i].exp_addr));
    end
    @(posedge clk); #1 req_vld = '0;
    wait_idle("table_drain");

    // Single request: response two cycles after the grant.
    do_reset();
    @(posedge clk); #1;
    req_vld = 3'b001;
    req_addr = {16'd0, 8'd5};
    @(negedge clk);
    chk("sr_ready", 32'(req_rdy), 32'd1);
    chk("sr_ce", 32'(ce), 32'd1);
    chk("sr_addr", 32'(sram_addr), 32'd5);
    @(posedge clk); #1 req_vld = '0;
    @(negedge clk);
    chk("sr_rsp_early", 32'(rsp_vld), 32'd0);
    @(negedge clk);
    chk("sr_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("sr_rsp_id", 32'(rsp_id), 32'd0);
    chk_data("sr_rsp_data", word_of(8'd5));
    wait_idle("sr_drain");

    // Continuous requests: rotating grants, one response per cycle after fill.
    do_reset();
    @(posedge clk); #1;
    req_vld = 3'b111;
    req_addr = {8'd30, 8'd20, 8'd10};
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_ready", c), 32'(req_rdy), 32'(3'b001 << (c % 3)));
      chk($sformatf("cont%0d_ce", c), 32'(ce), 32'd1);
      if (c >= 2) chk($sformatf("cont%0d_rsp_vld", c), 32'(rsp_vld), 32'd1);
    end
    @(posedge clk); #1 req_vld = '0;
    wait_idle("cont_drain");

    // Backpressure: only FIFO_DEPTH grants, head held stable, then in-order drain.
    do_reset();
    rsp_rdy = 1'b0;
    @(posedge clk); #1;
    req_vld = 3'b111;
    req_addr = {8'd30, 8'd20, 8'd10};
    gcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (|req_rdy) gcnt++;
      if (c == 3 || c == 5) begin
        chk($sformatf("bp%0d_rsp_vld", c), 32'(rsp_vld), 32'd1);
        chk($sformatf("bp%0d_rsp_id", c), 32'(rsp_id), 32'd0);
        chk_data($sformatf("bp%0d_rsp_data", c), word_of(8'd10));
      end
    end
    chk("bp_grants", 32'(gcnt), 32'(FIFO_DEPTH));
    chk("bp_ready_blocked", 32'(req_rdy), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    pops0 = mon_pops;
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    req_vld = '0;
    wait_idle("bp_drain");
    chk("bp_drain_count", 32'(mon_pops - pops0), 32'(FIFO_DEPTH));

    // Reset one cycle after a grant discards the read in flight.
    do_reset();
    @(posedge clk); #1;
    req_vld = 3'b001;
    req_addr = {16'd0, 8'd7};
    @(negedge clk);
    chk("mf_grant", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;
    req_vld = '0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    nv = 0;
    nb = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_vld) nv++;
      if (busy) nb++;
    end
    chk("mf_rsp_after_reset", 32'(nv), 32'd0);
    chk("mf_busy_after_reset", 32'(nb), 32'd0);
    @(posedge clk); #1 req_vld = 3'b111;
    @(negedge clk);
    chk("mf_next_grant", 32'(req_rdy), 32'd1);
    @(posedge clk); #1 req_vld = '0;
    wait_idle("mf_drain");

`ifdef SRAM_SCHED_PERF_EN
    // 3 grants then 4 credit-full cycles, then 7 more grants without stalls.
    do_reset();
    rsp_rdy = 1'b0;
    @(posedge clk); #1;
    req_vld = 3'b010;
    req_addr = {8'd0, 8'd4, 8'd0};
    repeat (7) @(posedge clk);
    #1;
    req_vld = '0;
    rsp_rdy = 1'b1;
    wait_idle("perf_drain1");
    @(posedge clk); #1 req_vld = 3'b010;
    repeat (7) @(posedge clk);
    #1 req_vld = '0;
    wait_idle("perf_drain2");
    @(negedge clk);
    chk("perf_grant_m1", 32'(perf_grant[15:0]), 32'd0);
    chk("perf_grant_m2", 32'(perf_grant[31:16]), 32'd10);
    chk("perf_grant_m3", 32'(perf_grant[47:32]), 32'd0);
    chk("perf_stall", 32'(perf_stall), 32'd4);
    @(posedge clk); #1 perf_clr = 1'b1;
    @(posedge clk); #1 perf_clr = 1'b0;
    @(negedge clk);
    chk("perf_clear_grant", 32'(perf_grant[31:16]), 32'd0);
    chk("perf_clear_stall", 32'(perf_stall), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
